// File: rtl/layer_compositor.sv
// Layer compositor: blends N_LAYERS prioritised sprite layers over a camera or
// black background and owns the START/PLAY/OVER screen FSM. The FSM and the
// layer enable mask only change on frame boundaries (nf_in). The pixel path is
// two register stages, and hcount/vcount are delayed by the same amount.
module layer_compositor #(
  parameter int unsigned N_LAYERS     = 6,
  parameter logic [23:0] KEY_COLOR    = 24'h00_00_00,
  parameter int unsigned BORDER_X     = 960,
  parameter int unsigned BORDER_Y     = 640,
  parameter logic [23:0] BORDER_COLOR = 24'hFF_FF_FF,
  parameter logic [31:0] START_CODE_A = 32'h20DF_5BA4,
  parameter logic [31:0] START_CODE_B = 32'h20DF_5AA5
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [10:0]              hcount_in,
  input  logic [9:0]               vcount_in,
  input  logic                     nf_in,
  input  logic [31:0]              ir_in,
  input  logic                     camera_sw,
  input  logic [23:0]              camera_pixel_in,
  input  logic [23:0]              start_pixel_in,
  input  logic [24*N_LAYERS-1:0]   layer_pixel_in,
  input  logic [N_LAYERS-1:0]      layer_valid_in,
  input  logic [N_LAYERS-1:0]      layer_en_in,
  input  logic [2:0]               player_health_in,
  input  logic [2:0]               opponent_health_in,
  output logic [23:0]              pixel_out,
  output logic [10:0]              hcount_out,
  output logic [9:0]               vcount_out,
  output logic [1:0]               game_state_out
);

  localparam logic [10:0] BX = BORDER_X[10:0];
  localparam logic [9:0]  BY = BORDER_Y[9:0];

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_PLAY  = 2'd1,
    ST_OVER  = 2'd2
  } state_t;

  state_t                 state_q;
  logic                   ir_pending_q;
  logic [N_LAYERS-1:0]    mask_q;

  logic                   ir_match;
  logic                   ir_go;

  assign ir_match = (ir_in == START_CODE_A) || (ir_in == START_CODE_B);
  // A code seen earlier in the frame or on the boundary cycle itself counts.
  assign ir_go    = ir_pending_q | ir_match;

  // Screen FSM, sticky IR flag and frame-latched enable mask; all commit on nf_in.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_START;
      ir_pending_q <= 1'b0;
      mask_q       <= '1;
    end else if (nf_in) begin
      case (state_q)
        ST_START: if (ir_go) state_q <= ST_PLAY;
        ST_PLAY:  if (player_health_in == 3'd0 || opponent_health_in == 3'd0)
                    state_q <= ST_OVER;
        ST_OVER:  if (ir_go) state_q <= ST_START;
        default:  state_q <= ST_START;
      endcase
      ir_pending_q <= 1'b0;
      mask_q       <= layer_en_in;
    end else if (ir_match) begin
      ir_pending_q <= 1'b1;
    end
  end

  logic [N_LAYERS-1:0]    opaque_d, opaque_q;
  logic                   border_d, border_q;
  logic [23:0]            bg_d, bg_q;
  logic [24*N_LAYERS-1:0] lpix_q;
  logic [23:0]            start_q;
  logic [10:0]            h1_q;
  logic [9:0]             v1_q;

  // Stage 1 decode: which layers are visible here, and is this a border pixel.
  always_comb begin
    opaque_d = '0;
    for (int i = 0; i < N_LAYERS; i++) begin
      opaque_d[i] = layer_valid_in[i] & mask_q[i] &
                    (layer_pixel_in[24*i +: 24] != KEY_COLOR);
    end
    border_d = ((hcount_in == BX) && (vcount_in <= BY)) ||
               ((vcount_in == BY) && (hcount_in <= BX));
    bg_d     = camera_sw ? camera_pixel_in : 24'h00_00_00;
  end

  // Stage 1 registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      opaque_q <= '0;
      border_q <= 1'b0;
      bg_q     <= '0;
      lpix_q   <= '0;
      start_q  <= '0;
      h1_q     <= '0;
      v1_q     <= '0;
    end else begin
      opaque_q <= opaque_d;
      border_q <= border_d;
      bg_q     <= bg_d;
      lpix_q   <= layer_pixel_in;
      start_q  <= start_pixel_in;
      h1_q     <= hcount_in;
      v1_q     <= vcount_in;
    end
  end

  logic [23:0] sel_d;
  logic [23:0] base_d;
  logic [23:0] pix_d;

  // Stage 2 select: scanning from the top index down lets layer 0 win last.
  always_comb begin
    sel_d = bg_q;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (opaque_q[i]) sel_d = lpix_q[24*i +: 24];
    end
    base_d = border_q ? BORDER_COLOR : sel_d;
    if (state_q == ST_START) begin
      pix_d = start_q;
    end else if (state_q == ST_OVER) begin
      pix_d = {1'b0, base_d[23:17], 1'b0, base_d[15:9], 1'b0, base_d[7:1]};
    end else begin
      pix_d = base_d;
    end
  end

  logic [23:0] pixel_q;
  logic [10:0] h2_q;
  logic [9:0]  v2_q;

  // Stage 2 registers driving the outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pixel_q <= '0;
      h2_q    <= '0;
      v2_q    <= '0;
    end else begin
      pixel_q <= pix_d;
      h2_q    <= h1_q;
      v2_q    <= v1_q;
    end
  end

  assign pixel_out      = pixel_q;
  assign hcount_out     = h2_q;
  assign vcount_out     = v2_q;
  assign game_state_out = state_q;

endmodule
